// File: rtl/multicycle_controller.sv
// Purpose : main control FSM for a multicycle MIPS-subset datapath (R-type, lw, sw, beq, j).
// Latency : outputs are combinational from the current state and inputs; state advances once per clk.
// Backpr. : FETCH, MEM_RD and MEM_WR stall while mem_ready=0; no other state waits.
//
// Ports:
//   clk, rst_n          - clock; asynchronous active-low reset (state forced to FETCH)
//   OpCode, Funct       - instruction register fields
//   mem_ready           - memory completes the current access this cycle
//   PCWr..ALUSrcA       - datapath enables/selects
//   ALUSrcB, PCSrc      - 2-bit mux selects
//   ALUCtr              - ALU operation code
//   retire              - instruction completes this cycle
//   illegal             - set only while parked in TRAP
//   state               - current FSM state code
// Build option: define ILLEGAL_TRAP_EN to park in TRAP on an illegal instruction;
// otherwise illegal instructions execute as a NOP and illegal stays 0.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       PCWr,
  output logic       PCWrCond,
  output logic       IorD,
  output logic       IRWr,
  output logic       MemRd,
  output logic       MemWr,
  output logic       RegDst,
  output logic       Mem2Reg,
  output logic       RegWr,
  output logic       ALUSrcA,
  output logic       retire,
  output logic       illegal,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [3:0] ALUCtr,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_WB_R     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_TRAP     = 4'd10
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  state_t cur_state, nxt_state;

  logic       is_r, is_lw, is_sw, is_beq, is_j, is_ill;
  logic [3:0] funct_alu;

  // Instruction decode; an R-type opcode with an unknown Funct is illegal.
  always_comb begin
    is_r      = 1'b0;
    funct_alu = ALU_ADD;
    if (OpCode == 6'h00) begin
      case (Funct)
        6'h20: begin is_r = 1'b1; funct_alu = ALU_ADD; end
        6'h22: begin is_r = 1'b1; funct_alu = ALU_SUB; end
        6'h24: begin is_r = 1'b1; funct_alu = ALU_AND; end
        6'h25: begin is_r = 1'b1; funct_alu = ALU_OR;  end
        6'h2a: begin is_r = 1'b1; funct_alu = ALU_SLT; end
        default: ;
      endcase
    end
  end

  assign is_lw  = (OpCode == 6'h23);
  assign is_sw  = (OpCode == 6'h2b);
  assign is_beq = (OpCode == 6'h04);
  assign is_j   = (OpCode == 6'h02);
  assign is_ill = !(is_r || is_lw || is_sw || is_beq || is_j);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= S_FETCH;
    else        cur_state <= nxt_state;
  end

  assign state = cur_state;

  always_comb begin
    nxt_state = S_FETCH;
    PCWr      = 1'b0;
    PCWrCond  = 1'b0;
    IorD      = 1'b0;
    IRWr      = 1'b0;
    MemRd     = 1'b0;
    MemWr     = 1'b0;
    RegDst    = 1'b0;
    Mem2Reg   = 1'b0;
    RegWr     = 1'b0;
    ALUSrcA   = 1'b0;
    retire    = 1'b0;
    illegal   = 1'b0;
    ALUSrcB   = 2'b00;
    PCSrc     = 2'b00;
    ALUCtr    = 4'b0000;

    case (cur_state)
      S_FETCH: begin
        MemRd   = 1'b1;
        ALUSrcB = 2'b01;
        ALUCtr  = ALU_ADD;
        // IR load and PC+4 happen only on the cycle memory delivers the word.
        IRWr    = mem_ready;
        PCWr    = mem_ready;
        nxt_state = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target precomputed into ALUOut while the opcode is decoded.
        ALUSrcB = 2'b11;
        ALUCtr  = ALU_ADD;
        if (is_r)                nxt_state = S_EXEC_R;
        else if (is_lw || is_sw) nxt_state = S_MEM_ADDR;
        else if (is_beq)         nxt_state = S_BRANCH;
        else if (is_j)           nxt_state = S_JUMP;
        else if (is_ill) begin
`ifdef ILLEGAL_TRAP_EN
          nxt_state = S_TRAP;
`else
          nxt_state = S_FETCH;
`endif
        end
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUCtr  = ALU_ADD;
        if (is_lw)      nxt_state = S_MEM_RD;
        else if (is_sw) nxt_state = S_MEM_WR;
      end
      S_MEM_RD: begin
        MemRd     = 1'b1;
        IorD      = 1'b1;
        nxt_state = mem_ready ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        RegWr   = 1'b1;
        Mem2Reg = 1'b1;
        retire  = 1'b1;
      end
      S_MEM_WR: begin
        MemWr     = 1'b1;
        IorD      = 1'b1;
        retire    = mem_ready;
        nxt_state = mem_ready ? S_FETCH : S_MEM_WR;
      end
      S_EXEC_R: begin
        ALUSrcA   = 1'b1;
        ALUCtr    = funct_alu;
        nxt_state = S_WB_R;
      end
      S_WB_R: begin
        RegWr  = 1'b1;
        RegDst = 1'b1;
        retire = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUCtr   = ALU_SUB;
        PCWrCond = 1'b1;
        PCSrc    = 2'b01;
        retire   = 1'b1;
      end
      S_JUMP: begin
        PCWr   = 1'b1;
        PCSrc  = 2'b10;
        retire = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        // Parked until reset.
        illegal   = 1'b1;
        nxt_state = S_TRAP;
      end
`endif
      default: nxt_state = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the driver builds each instruction's
// expected cycle-by-cycle trace from its class and memory wait counts, and a
// negedge monitor compares every DUT cycle and every retire-to-retire length.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] OpCode, Funct;
  logic       mem_ready;
  logic       PCWr, PCWrCond, IorD, IRWr, MemRd, MemWr, RegDst, Mem2Reg, RegWr, ALUSrcA, retire, illegal;
  logic [1:0] ALUSrcB, PCSrc;
  logic [3:0] ALUCtr, state;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready),
    .PCWr(PCWr), .PCWrCond(PCWrCond), .IorD(IorD), .IRWr(IRWr), .MemRd(MemRd), .MemWr(MemWr),
    .RegDst(RegDst), .Mem2Reg(Mem2Reg), .RegWr(RegWr), .ALUSrcA(ALUSrcA), .retire(retire),
    .illegal(illegal), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUCtr(ALUCtr), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic pcwr, pcwrcond, iord, irwr, memrd, memwr, regdst, mem2reg, regwr, alusrca, retire, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] aluctr;
  } obs_t;

  localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_J = 4, K_ILL = 5;

  obs_t exp_q[$];
  int   len_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [5:0] r_funct[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
  logic [3:0] r_alu[5]   = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};

  // Expected outputs per state, straight from the control table.
  function automatic obs_t expect_for(input int ph, input logic mr, input logic [3:0] alu);
    obs_t o;
    o    = '0;
    o.st = ph[3:0];
    case (ph)
      0:  begin o.memrd = 1; o.alusrcb = 2'b01; o.aluctr = 4'b0010; o.irwr = mr; o.pcwr = mr; end
      1:  begin o.alusrcb = 2'b11; o.aluctr = 4'b0010; end
      2:  begin o.alusrca = 1; o.alusrcb = 2'b10; o.aluctr = 4'b0010; end
      3:  begin o.memrd = 1; o.iord = 1; end
      4:  begin o.regwr = 1; o.mem2reg = 1; o.retire = 1; end
      5:  begin o.memwr = 1; o.iord = 1; o.retire = mr; end
      6:  begin o.alusrca = 1; o.alusrcb = 2'b00; o.aluctr = alu; end
      7:  begin o.regwr = 1; o.regdst = 1; o.retire = 1; end
      8:  begin o.alusrca = 1; o.aluctr = 4'b0110; o.pcwrcond = 1; o.pcsrc = 2'b01; o.retire = 1; end
      9:  begin o.pcwr = 1; o.pcsrc = 2'b10; o.retire = 1; end
      10: begin o.illegal = 1; end
      default: ;
    endcase
    return o;
  endfunction

  // Monitor: compare every cycle, and on each retire compare instruction length.
  int   cyc_cnt = 0;
  logic [3:0] prev_st = 4'd0;
  always @(negedge clk) begin
    obs_t act, e;
    act = {state, PCWr, PCWrCond, IorD, IRWr, MemRd, MemWr, RegDst, Mem2Reg, RegWr,
           ALUSrcA, retire, illegal, ALUSrcB, PCSrc, ALUCtr};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t got=%h want=%h (state got %0d want %0d)",
                 $time, act, e, act.st, e.st);
      end
    end
    if (!rst_n) begin
      cyc_cnt = 0;
      prev_st = 4'd0;
    end else begin
      if (state == 4'd0 && prev_st != 4'd0) cyc_cnt = 1;
      else cyc_cnt++;
      prev_st = state;
      if (retire === 1'b1) begin
        checks++;
        if (len_q.size() == 0) begin
          errors++;
          $display("FAIL retire_len unexpected retire at t=%0t after %0d cycles", $time, cyc_cnt);
        end else begin
          int want;
          want = len_q.pop_front();
          if (cyc_cnt != want) begin
            errors++;
            $display("FAIL retire_len t=%0t got=%0d cycles want=%0d", $time, cyc_cnt, want);
          end
        end
      end
    end
  end

  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic mr, input obs_t e);
    OpCode    = op;
    Funct     = fn;
    mem_ready = mr;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int kind,
                           input logic [3:0] alu, input int fw, input int mw);
    logic m;
    case (kind)
      K_R:           len_q.push_back(fw + 4);
      K_LW:          len_q.push_back(fw + mw + 5);
      K_SW:          len_q.push_back(fw + mw + 4);
      K_BEQ, K_J:    len_q.push_back(fw + 3);
      default: ;
    endcase
    for (int i = 0; i < fw; i++) step(op, fn, 1'b0, expect_for(0, 1'b0, 4'd0));
    step(op, fn, 1'b1, expect_for(0, 1'b1, 4'd0));
    m = rb(); step(op, fn, m, expect_for(1, m, 4'd0));
    case (kind)
      K_R: begin
        m = rb(); step(op, fn, m, expect_for(6, m, alu));
        m = rb(); step(op, fn, m, expect_for(7, m, 4'd0));
      end
      K_LW: begin
        m = rb(); step(op, fn, m, expect_for(2, m, 4'd0));
        for (int i = 0; i < mw; i++) step(op, fn, 1'b0, expect_for(3, 1'b0, 4'd0));
        step(op, fn, 1'b1, expect_for(3, 1'b1, 4'd0));
        m = rb(); step(op, fn, m, expect_for(4, m, 4'd0));
      end
      K_SW: begin
        m = rb(); step(op, fn, m, expect_for(2, m, 4'd0));
        for (int i = 0; i < mw; i++) step(op, fn, 1'b0, expect_for(5, 1'b0, 4'd0));
        step(op, fn, 1'b1, expect_for(5, 1'b1, 4'd0));
      end
      K_BEQ: begin m = rb(); step(op, fn, m, expect_for(8, m, 4'd0)); end
      K_J:   begin m = rb(); step(op, fn, m, expect_for(9, m, 4'd0)); end
      default: ;  // illegal NOP: DECODE falls straight back to FETCH
    endcase
  endtask

  task automatic reset_cycles(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      logic m;
      m = rb();
      step(6'h00, 6'h20, m, expect_for(0, m, 4'd0));
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] op, fn;
    int k, idx;
    rst_n = 1'b0; OpCode = 6'h00; Funct = 6'h20; mem_ready = 1'b0;
    @(posedge clk); #1;
    reset_cycles(3);

    // Directed: sub, lw with two read waits, beq, j, illegal 0x3f.
    run_instr(6'h00, 6'h22, K_R, 4'b0110, 0, 0);
    run_instr(6'h23, 6'h00, K_LW, 4'd0, 0, 2);
    run_instr(6'h04, 6'h00, K_BEQ, 4'd0, 0, 0);
    run_instr(6'h02, 6'h00, K_J, 4'd0, 0, 0);
`ifndef ILLEGAL_TRAP_EN
    run_instr(6'h3f, 6'h00, K_ILL, 4'd0, 0, 0);
`endif

    // Reset arriving mid-cycle while a store waits on memory.
    step(6'h2b, 6'h00, 1'b1, expect_for(0, 1'b1, 4'd0));
    step(6'h2b, 6'h00, 1'b1, expect_for(1, 1'b1, 4'd0));
    step(6'h2b, 6'h00, 1'b0, expect_for(2, 1'b0, 4'd0));
    step(6'h2b, 6'h00, 1'b0, expect_for(5, 1'b0, 4'd0));
    mem_ready = 1'b0;
    exp_q.push_back(expect_for(0, 1'b0, 4'd0));
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || MemWr !== 1'b0 || retire !== 1'b0 || MemRd !== 1'b1) begin
      errors++;
      $display("FAIL async_reset state=%0d MemWr=%b retire=%b MemRd=%b want 0/0/0/1",
               state, MemWr, retire, MemRd);
    end
    @(posedge clk); #1;
    reset_cycles(2);

    // Randomised instruction mix with random memory wait counts.
    for (int n = 0; n < 60; n++) begin
`ifdef ILLEGAL_TRAP_EN
      k = $urandom_range(0, 8);
`else
      k = $urandom_range(0, 9);
`endif
      fn = 6'($urandom_range(0, 63));
      if (k <= 4) begin
        idx = k;
        run_instr(6'h00, r_funct[idx], K_R, r_alu[idx], $urandom_range(0, 2), 0);
      end else if (k == 5) run_instr(6'h23, fn, K_LW, 4'd0, $urandom_range(0, 2), $urandom_range(0, 3));
      else if (k == 6) run_instr(6'h2b, fn, K_SW, 4'd0, $urandom_range(0, 2), $urandom_range(0, 3));
      else if (k == 7) run_instr(6'h04, fn, K_BEQ, 4'd0, $urandom_range(0, 2), 0);
      else if (k == 8) run_instr(6'h02, fn, K_J, 4'd0, $urandom_range(0, 2), 0);
      else begin
        if (rb()) begin
          op = 6'h00; fn = 6'h21;
        end else begin
          op = 6'($urandom_range(1, 63));
          if (op == 6'h02 || op == 6'h04 || op == 6'h23 || op == 6'h2b) op = 6'h3f;
        end
        run_instr(op, fn, K_ILL, 4'd0, $urandom_range(0, 2), 0);
      end
    end

`ifdef ILLEGAL_TRAP_EN
    // Illegal instruction parks the FSM in TRAP until reset.
    run_instr(6'h3f, 6'h00, K_ILL, 4'd0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      logic m;
      m = rb();
      step(6'h00, 6'h20, m, expect_for(10, m, 4'd0));
    end
    reset_cycles(2);
    run_instr(6'h00, 6'h2a, K_R, 4'b0111, 0, 0);
`endif

    checks++;
    if (exp_q.size() != 0 || len_q.size() != 0) begin
      errors++;
      $display("FAIL drain exp_q=%0d len_q=%0d want 0/0", exp_q.size(), len_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous reset, active-low.
REQ-003 SHALL have ports OpCode, input, 6 bits, and Funct, input, 6 bits, both taken from the instruction register.
REQ-004 SHALL have port mem_ready, input, 1 bit: memory completes the current access this cycle.
REQ-005 SHALL have 1-bit outputs PCWr, PCWrCond, IorD, IRWr, MemRd, MemWr, RegDst, Mem2Reg, RegWr, ALUSrcA, retire and illegal.
REQ-006 SHALL have 2-bit outputs ALUSrcB (00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2) and PCSrc (00 ALU result, 01 ALUOut, 10 jump target).
REQ-007 SHALL have outputs ALUCtr (4 bits) and state (4 bits, current FSM state).

Function
REQ-008 SHALL decode add/sub/and/or/slt (OpCode 0x00, Funct 0x20/0x22/0x24/0x25/0x2a), lw 0x23, sw 0x2b, beq 0x04 and j 0x02; every other OpCode/Funct pair is illegal.
REQ-009 SHALL encode ALUCtr as add 0010, sub 0110, and 0000, or 0001, slt 0111.
REQ-010 SHALL use the state encoding FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC_R 6, WB_R 7, BRANCH 8, JUMP 9, TRAP 10; codes 11-15 SHALL go to FETCH.
REQ-011 SHALL drive these outputs in FETCH: MemRd=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUCtr=add, PCSrc=00, IRWr=PCWr=mem_ready; the FSM SHALL hold in FETCH while mem_ready=0.
REQ-012 SHALL drive these outputs in DECODE: ALUSrcA=0, ALUSrcB=11, ALUCtr=add. Next state: R-type -> EXEC_R; lw/sw -> MEM_ADDR; beq -> BRANCH; j -> JUMP; illegal -> per REQ-022/023.
REQ-013 SHALL drive these outputs in MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUCtr=add. Next state: lw -> MEM_RD, sw -> MEM_WR.
REQ-014 SHALL drive MemRd=1 and IorD=1 in MEM_RD, holding there until mem_ready=1 and then going to MEM_WB.
REQ-015 SHALL drive RegWr=1, Mem2Reg=1, RegDst=0 and retire=1 in MEM_WB, then go to FETCH.
REQ-016 SHALL drive MemWr=1 and IorD=1 in MEM_WR, holding there until mem_ready=1; on the mem_ready=1 cycle retire=1 and the next state is FETCH.
REQ-017 SHALL drive ALUSrcA=1, ALUSrcB=00 and ALUCtr from Funct in EXEC_R, then go to WB_R.
REQ-018 SHALL drive RegWr=1, RegDst=1, Mem2Reg=0 and retire=1 in WB_R, then go to FETCH.
REQ-019 SHALL drive ALUSrcA=1, ALUSrcB=00, ALUCtr=sub, PCWrCond=1, PCSrc=01 and retire=1 in BRANCH, then go to FETCH.
REQ-020 SHALL drive PCWr=1, PCSrc=10 and retire=1 in JUMP, then go to FETCH.
REQ-021 SHALL drive every output not listed for a state to 0; all outputs SHALL be combinational from state, OpCode, Funct and mem_ready, with one cycle of state latency.

Reset
REQ-022 SHALL, while rst_n=0, force state to FETCH immediately and independent of clk, and clear illegal; the FETCH outputs of REQ-011 then apply.
REQ-023 SHALL abort any in-flight access on reset (including MEM_RD/MEM_WR waits) without completing it, and SHALL start fetching on the first clk edge after rst_n rises.

Configuration
REQ-024 SHALL, with ILLEGAL_TRAP_EN defined, send DECODE with an illegal instruction to TRAP; TRAP SHALL hold illegal=1 and all other outputs 0, and SHALL be left only by reset.
REQ-025 SHALL, without ILLEGAL_TRAP_EN, send DECODE with an illegal instruction to FETCH with retire=0 (treated as a NOP), keep illegal tied to 0, and never reach TRAP.

Verification
REQ-026 With mem_ready=1 throughout, OpCode 0x00 and Funct 0x22, the FSM SHALL follow FETCH,DECODE,EXEC_R,WB_R (4 cycles), with ALUCtr=0110 in EXEC_R and RegWr=RegDst=retire=1 in WB_R.
REQ-027 For lw (0x23) with mem_ready=0 for the first 2 MEM_RD cycles, the instruction SHALL take 7 cycles, with MemRd=IorD=1 in each MEM_RD cycle and Mem2Reg=RegWr=1 in MEM_WB.
REQ-028 With mem_ready=1, beq (0x04) SHALL complete in 3 cycles with PCWrCond=1, PCSrc=01, ALUCtr=0110, and j (0x02) SHALL complete in 3 cycles with PCWr=1, PCSrc=10.
REQ-029 For OpCode 0x3f: with ILLEGAL_TRAP_EN the FSM SHALL reach state=10, illegal=1, and stay there 20 cycles until rst_n=0; without it, DECODE SHALL be followed by FETCH with illegal=0.
REQ-030 If rst_n=0 arrives mid-cycle during MEM_WR with mem_ready=0, state SHALL become 0 before the next clk edge, MemWr SHALL fall at once, and retire SHALL never pulse.
